// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC decode/control slice: field widths,
// opcode and ALU-operation encodings, instruction classes, the decoded
// instruction payload and the control FSM state type.
package nrisc_pkg;

   localparam int unsigned INSTR_W  = 8;
   localparam int unsigned OPC_W    = 3;
   localparam int unsigned REG_W    = 3;
   localparam int unsigned ALU_W    = 2;
   localparam int unsigned RETIRE_W = 16;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_LD   = 3'b100,
      OP_ST   = 3'b101,
      OP_NOP  = 3'b110,
      OP_HALT = 3'b111
   } opcode_e;

   localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALU_W-1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      CLS_ALU,
      CLS_MEM,
      CLS_NOP,
      CLS_HALT
   } iclass_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_HALTED
   } state_e;

   typedef struct packed {
      opcode_e          opcode;
      logic [REG_W-1:0] ra;
      logic [REG_W-1:0] rb;
      iclass_e          iclass;
   } decoded_t;

   // ALU operation selected by an arithmetic/logic opcode
   function automatic logic [ALU_W-1:0] alu_of(input opcode_e op);
      logic [ALU_W-1:0] r;
      r = ALU_ADD;
      unique case (op)
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_OR:   r = ALU_OR;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational field extraction for one instruction byte.
// Ports:
//   instr    - instruction byte: opcode[7:5], ra[4:2], rb[1:0]
//   fields_c - opcode, ra, rb (zero-extended, R0-R3 only) and class
module decode_fields
   import nrisc_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output decoded_t           fields_c
);

   opcode_e opc;

   always_comb begin
      opc             = opcode_e'(instr[7:5]);
      fields_c        = '0;
      fields_c.opcode = opc;
      fields_c.ra     = instr[4:2];
      fields_c.rb     = {1'b0, instr[1:0]};
      fields_c.iclass = CLS_ALU;
      unique case (opc)
         OP_LD, OP_ST: fields_c.iclass = CLS_MEM;
         OP_NOP:       fields_c.iclass = CLS_NOP;
         OP_HALT:      fields_c.iclass = CLS_HALT;
         default:      fields_c.iclass = CLS_ALU;
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// Multi-cycle decode/control FSM for the nRISC core. Accepts one
// instruction byte when idle, sequences register reads, ALU op, memory
// request (with timeout abort) and write-back.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   instr_valid/instr     - instruction offer; instr_ready when idle
//   read1, read2          - register read addresses (DECODE, EXEC)
//   reg_write/write_dest/wb_sel - write-back strobe, address, source
//   alu_op                - ALU operation (EXEC only)
//   mem_read/mem_write    - load/store request, mem_done completes it
//   busy, halted, mem_err - status; mem_err sticky until reset
//   retired               - completed-instruction count, present only
//                           when RETIRE_COUNT_EN is defined
// All outputs are registered: they are computed from the state being
// entered so each appears in the same cycle as its owning state.
module decode_ctrl
   import nrisc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                instr_valid,
   input  logic [INSTR_W-1:0]  instr,
   output logic                instr_ready,
   output logic [REG_W-1:0]    read1,
   output logic [REG_W-1:0]    read2,
   output logic                reg_write,
   output logic [REG_W-1:0]    write_dest,
   output logic                wb_sel,
   output logic [ALU_W-1:0]    alu_op,
   output logic                mem_read,
   output logic                mem_write,
   input  logic                mem_done,
   output logic                busy,
   output logic                halted,
`ifdef RETIRE_COUNT_EN
   output logic [RETIRE_W-1:0] retired,
`endif
   output logic                mem_err
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mem_err_d;
   decoded_t           dec_c;

   logic               instr_ready_d, reg_write_d, wb_sel_d;
   logic               mem_read_d, mem_write_d, busy_d, halted_d;
   logic [REG_W-1:0]   read1_d, read2_d, write_dest_d;
   logic [ALU_W-1:0]   alu_op_d;

   // Fields of the instruction held (or being captured) this cycle
   decode_fields u_fields (
      .instr    (instr_d),
      .fields_c (dec_c)
   );

   // Next state plus outputs for the state being entered
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      cnt_d         = cnt_q;
      mem_err_d     = mem_err;
      instr_ready_d = 1'b0;
      reg_write_d   = 1'b0;
      wb_sel_d      = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
      halted_d      = 1'b0;
      read1_d       = '0;
      read2_d       = '0;
      write_dest_d  = '0;
      alu_op_d      = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            unique case (dec_c.iclass)
               CLS_ALU:  state_d = ST_EXEC;
               CLS_MEM: begin
                  state_d = ST_MEM;
                  cnt_d   = '0;
               end
               CLS_NOP:  state_d = ST_IDLE;
               default:  state_d = ST_HALTED;
            endcase
         end
         ST_EXEC: state_d = ST_WB;
         ST_MEM: begin
            // completion takes priority over a timeout in the same cycle
            if (mem_done) begin
               state_d = (dec_c.opcode == OP_LD) ? ST_WB : ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               mem_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WB:     state_d = ST_IDLE;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_IDLE: instr_ready_d = 1'b1;
         ST_DECODE: begin
            read1_d = dec_c.ra;
            read2_d = dec_c.rb;
         end
         ST_EXEC: begin
            read1_d  = dec_c.ra;
            read2_d  = dec_c.rb;
            alu_op_d = alu_of(dec_c.opcode);
         end
         ST_MEM: begin
            mem_read_d  = (dec_c.opcode == OP_LD);
            mem_write_d = (dec_c.opcode == OP_ST);
         end
         ST_WB: begin
            reg_write_d  = 1'b1;
            write_dest_d = dec_c.ra;
            wb_sel_d     = (dec_c.opcode == OP_LD);
         end
         ST_HALTED: halted_d = 1'b1;
         default:   instr_ready_d = 1'b0;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, latched instruction, timeout counter and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         cnt_q       <= '0;
         mem_err     <= 1'b0;
         instr_ready <= 1'b1;
         read1       <= '0;
         read2       <= '0;
         reg_write   <= 1'b0;
         write_dest  <= '0;
         wb_sel      <= 1'b0;
         alu_op      <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         cnt_q       <= cnt_d;
         mem_err     <= mem_err_d;
         instr_ready <= instr_ready_d;
         read1       <= read1_d;
         read2       <= read2_d;
         reg_write   <= reg_write_d;
         write_dest  <= write_dest_d;
         wb_sel      <= wb_sel_d;
         alu_op      <= alu_op_d;
         mem_read    <= mem_read_d;
         mem_write   <= mem_write_d;
         busy        <= busy_d;
         halted      <= halted_d;
      end
   end

`ifdef RETIRE_COUNT_EN
   logic retire_c;

   // Completion events; a timeout abort is not a completion
   always_comb begin
      retire_c = 1'b0;
      unique case (state_q)
         ST_DECODE: retire_c = (dec_c.iclass == CLS_NOP) || (dec_c.iclass == CLS_HALT);
         ST_MEM:    retire_c = mem_done && (dec_c.opcode == OP_ST);
         ST_WB:     retire_c = 1'b1;
         default:   retire_c = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired <= '0;
      end else if (retire_c) begin
         retired <= retired + RETIRE_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_decode_ctrl.sv
// Scoreboard bench for decode_ctrl: the driver predicts each instruction's
// cycle timeline and write-back payload from the instruction rules; a
// separate monitor pops write-back payloads whenever reg_write appears.
module tb_decode_ctrl;

   localparam int MEM_T = 15;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [7:0]  instr;
   logic        instr_ready;
   logic [2:0]  read1, read2, write_dest;
   logic        reg_write, wb_sel;
   logic [1:0]  alu_op;
   logic        mem_read, mem_write, mem_done;
   logic        busy, halted, mem_err;
`ifdef RETIRE_COUNT_EN
   logic [15:0] retired;
`endif

   typedef struct packed {
      logic       rdy;
      logic       bsy;
      logic       hlt;
      logic       err;
      logic [2:0] r1;
      logic [2:0] r2;
      logic [1:0] alu;
      logic       mrd;
      logic       mwr;
      logic       rw;
   } exp_t;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        tl[$];
   logic [3:0]  wr_q[$];
   logic [3:0]  exp_w;
   logic        model_err;
   logic [15:0] model_ret;

   decode_ctrl #(.MEM_TIMEOUT(MEM_T)) dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .read1       (read1),
      .read2       (read2),
      .reg_write   (reg_write),
      .write_dest  (write_dest),
      .wb_sel      (wb_sel),
      .alu_op      (alu_op),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_done    (mem_done),
      .busy        (busy),
      .halted      (halted),
`ifdef RETIRE_COUNT_EN
      .retired     (retired),
`endif
      .mem_err     (mem_err)
   );

   always #5 clock = ~clock;

   function automatic void chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void chk_out(input string name, input exp_t e);
      exp_t a;
      a = {instr_ready, busy, halted, mem_err, read1, read2, alu_op, mem_read, mem_write, reg_write};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: rdy/busy/hlt/err/r1/r2/alu/mrd/mwr/rw got %b expected %b", name, a, e);
      end
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e     = '0;
      e.rdy = 1'b1;
      e.err = model_err;
      return e;
   endfunction

   // Reference: per-cycle timeline after acceptance, write-back payload and
   // status updates, derived from the instruction's semantics.
   function automatic exp_t build(input logic [7:0] ins, input int done_at);
      logic [2:0] op, ra, rb;
      exp_t       e;
      int         n;
      logic       done;
      op = ins[7:5];
      ra = ins[4:2];
      rb = {1'b0, ins[1:0]};
      tl.delete();
      e     = '0;
      e.bsy = 1'b1;
      e.err = model_err;
      e.r1  = ra;
      e.r2  = rb;
      tl.push_back(e);
      if (op <= 3'd3) begin
         e.alu = op[1:0];
         tl.push_back(e);
         e.r1 = '0; e.r2 = '0; e.alu = '0; e.rw = 1'b1;
         tl.push_back(e);
         wr_q.push_back({ra, 1'b0});
         model_ret++;
      end else if (op <= 3'd5) begin
         done = (done_at >= 1) && (done_at <= MEM_T);
         n    = done ? done_at : MEM_T;
         e.r1 = '0; e.r2 = '0;
         e.mrd = (op == 3'd4);
         e.mwr = (op == 3'd5);
         repeat (n) tl.push_back(e);
         e.mrd = 1'b0; e.mwr = 1'b0;
         if (!done) begin
            model_err = 1'b1;
         end else begin
            model_ret++;
            if (op == 3'd4) begin
               e.rw = 1'b1;
               tl.push_back(e);
               wr_q.push_back({ra, 1'b1});
            end
         end
      end else begin
         model_ret++;
      end
      e = idle_exp();
      if (op == 3'd7) begin
         e.rdy = 1'b0;
         e.bsy = 1'b1;
         e.hlt = 1'b1;
      end
      return e;
   endfunction

   // Called just after a negedge; leaves the bench at a negedge with DUT idle
   task automatic do_reset();
      #2;
      reset       = 1'b1;
      instr_valid = 1'b0;
      mem_done    = 1'b0;
      wr_q.delete();
      model_err   = 1'b0;
      model_ret   = '0;
      #1;
      chk_out("reset_async", idle_exp());
`ifdef RETIRE_COUNT_EN
      chk_val("reset_retired", 32'(retired), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      chk_out("reset_release", idle_exp());
   endtask

   // Offer one instruction; done_at = MEM cycle carrying mem_done (0 = never);
   // abort_at = timeline index after which reset is applied (-1 = none)
   task automatic run_instr(input logic [7:0] ins, input int done_at, input int abort_at);
      exp_t fin;
      logic is_mem;
      fin    = build(ins, done_at);
      is_mem = (ins[7:6] == 2'b10);
      instr_valid = 1'b1;
      instr       = ins;
      for (int j = 0; j < tl.size(); j++) begin
         @(negedge clock);
         chk_out($sformatf("op%0d_ins%02h_cyc%0d", ins[7:5], ins, j), tl[j]);
         instr_valid = 1'($urandom);
         instr       = 8'($urandom);
         if (is_mem && j >= 1 && j <= MEM_T) mem_done = (j == done_at);
         else                                mem_done = 1'($urandom);
         if (j == abort_at) begin
            do_reset();
            return;
         end
      end
      @(negedge clock);
      chk_out($sformatf("op%0d_ins%02h_end", ins[7:5], ins), fin);
`ifdef RETIRE_COUNT_EN
      chk_val("retired", 32'(retired), 32'(model_ret));
`endif
      instr_valid = 1'b0;
      mem_done    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         chk_out("idle", idle_exp());
         instr_valid = 1'b0;
         mem_done    = 1'($urandom);
      end
      mem_done = 1'b0;
   endtask

   task automatic halted_hold(input int n);
      exp_t e;
      e     = idle_exp();
      e.rdy = 1'b0;
      e.bsy = 1'b1;
      e.hlt = 1'b1;
      repeat (n) begin
         instr_valid = 1'b1;
         instr       = 8'($urandom);
         mem_done    = 1'($urandom);
         @(negedge clock);
         chk_out("halt_hold", e);
      end
   endtask

   // Monitor: every write-back must match the oldest predicted payload
   always @(negedge clock) begin
      if (!reset) begin
         if (reg_write) begin
            if (wr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got dest %0d wb_sel %0d, required no write", write_dest, wb_sel);
            end else begin
               exp_w = wr_q.pop_front();
               chk_val("wb_payload", 32'({write_dest, wb_sel}), 32'(exp_w));
            end
         end else begin
            chk_val("wb_fields_quiet", 32'({write_dest, wb_sel}), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ins;
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      mem_done    = 1'b0;
      model_err   = 1'b0;
      model_ret   = '0;
      @(negedge clock);
      chk_out("reset_state", idle_exp());
      reset = 1'b0;
      @(negedge clock);
      chk_out("post_reset", idle_exp());

      run_instr(8'b000_101_10, 0, -1);      // ADD r5, r2
      run_instr(8'b100_011_01, 4, -1);      // LD r3 <- mem[r1], done in 4th MEM cycle
      run_instr(8'b101_010_11, 0, -1);      // ST, never completes -> timeout
      idle(2);
      run_instr(8'b100_110_10, MEM_T, -1);  // completion on the timeout cycle wins
      run_instr(8'b101_001_00, 1, -1);      // ST completing immediately
      run_instr(8'hC5, 0, -1);              // NOP
      run_instr(8'b011_111_11, 0, -1);      // OR r7, r3

      for (int i = 0; i < 40; i++) begin
         ins = 8'($urandom);
         if (ins[7:5] == 3'b111) ins[7:5] = 3'b110;
         run_instr(ins, int'($urandom_range(0, MEM_T + 2)), -1);
         idle(int'($urandom_range(0, 2)));
      end

      run_instr(8'b100_111_11, 6, 2);       // reset during 2nd MEM cycle of LD
      idle(4);
      run_instr(8'b001_100_01, 0, 2);       // reset during the WB cycle
      idle(4);

      run_instr(8'hE0, 0, -1);              // HALT with valid held afterwards
      halted_hold(6);
      do_reset();
      idle(2);

`ifdef RETIRE_COUNT_EN
      do_reset();
      run_instr(8'b000_001_01, 0, -1);
      run_instr(8'b000_010_10, 0, -1);
      run_instr(8'b000_011_11, 0, -1);
      run_instr(8'b101_000_00, 0, -1);
      chk_val("retired_three_adds", 32'(retired), 32'd3);
`endif

      chk_val("write_queue_drained", 32'(wr_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max cycles in MEM waiting for mem_done before abort.
REQ-002 SHALL have ports (clock and reset first):
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- instr_valid  in  1  instruction byte available.
- instr  in  8  instruction: opcode[7:5], ra[4:2], rb[1:0].
- instr_ready  out  1  block accepts instr this cycle.
- read1  out  3  register-bank read port 1 address.
- read2  out  3  register-bank read port 2 address.
- reg_write  out  1  register-bank write strobe.
- write_dest  out  3  register-bank write address.
- wb_sel  out  1  write-data source select: 0 = ALU, 1 = memory.
- alu_op  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- mem_read  out  1  load request.
- mem_write  out  1  store request.
- mem_done  in  1  memory completion.
- busy  out  1  high in every state except IDLE.
- halted  out  1  HALT executed.
- mem_err  out  1  sticky memory-timeout flag.

Function
REQ-003 SHALL decode opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR (ra <= ra op rb); 100 LD (ra <= mem[rb]); 101 ST (mem[rb] <= ra); 110 NOP; 111 HALT.
REQ-004 SHALL form rb as {1'b0, instr[1:0]} (R0-R3 only); ra is the full 3-bit field.
REQ-005 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, WB, HALTED.
REQ-006 IDLE: instr_ready=1; on instr_valid=1, latch instr and move to DECODE; otherwise stay.
REQ-007 DECODE: read1=ra, read2=rb; ALU ops -> EXEC; LD/ST -> MEM with timeout counter cleared; NOP -> IDLE; HALT -> HALTED.
REQ-008 EXEC: alu_op driven from opcode[1:0] for exactly one cycle, read1/read2 held; -> WB.
REQ-009 MEM: mem_read (LD) or mem_write (ST) held high until mem_done=1. On mem_done, LD -> WB, ST -> IDLE. mem_done is ignored outside MEM.
REQ-010 MEM timeout: if the counter reaches MEM_TIMEOUT cycles without mem_done, the FSM SHALL set mem_err, deassert the request and go to IDLE with no write-back. mem_done arriving in the same cycle as the timeout SHALL win.
REQ-011 WB: reg_write=1 for exactly one cycle, write_dest=ra, wb_sel=1 for LD and 0 for ALU ops; -> IDLE.
REQ-012 Latency for ALU ops: reg_write SHALL be high in the third cycle after the accepting edge (DECODE, EXEC, WB). Throughput is one instruction per 4 cycles.
REQ-013 HALTED: halted=1, instr_ready=0, no strobes; SHALL remain until reset.
REQ-014 All strobes (reg_write, mem_read, mem_write) SHALL be zero outside their owning state; read1, read2, write_dest, alu_op SHALL be 0 when not driven.

Reset
REQ-015 Reset SHALL take effect asynchronously at any time, including mid-MEM or mid-WB. It SHALL force IDLE, clear the latched instruction, timeout counter, mem_err and halted, and drive all outputs to 0 except instr_ready=1.
REQ-016 A write strobe interrupted by reset SHALL NOT be completed after reset release.

Configuration
REQ-017 With RETIRE_COUNT_EN defined, the block SHALL add output retired[15:0]. It increments by 1 on each instruction completion: WB exit, ST mem_done, NOP decode, or HALT decode, but not a timeout abort. It wraps from 16'hFFFF to 0 and is reset to 0.
REQ-018 Without RETIRE_COUNT_EN, the port and counter SHALL be absent and all other behaviour is unchanged.

Structure
REQ-019 Opcode constants, alu_op encodings and the FSM state typedef SHALL live in shared package nrisc_pkg.
REQ-020 A combinational sub-module decode_fields SHALL extract opcode, ra, rb and instruction class from the latched instr.

Verification
REQ-021 Scenario: reset, then ADD instr=8'b000_101_10 -> read1=5 and read2=2 in DECODE; alu_op=00 in EXEC; reg_write=1 with write_dest=5 and wb_sel=0 exactly 3 cycles after accept.
REQ-022 Scenario: LD instr=8'b100_011_01 with mem_done after 4 cycles -> mem_read high for 4 cycles; then reg_write=1, write_dest=3, wb_sel=1.
REQ-023 Scenario: ST with mem_done never asserted -> mem_write drops after 15 MEM cycles; mem_err=1; no reg_write; instr_ready=1 next cycle.
REQ-024 Scenario: HALT 8'hE0, then instr_valid held high -> halted=1, instr_ready stays 0, no strobes, until reset clears halted.
REQ-025 Scenario: reset asserted mid-MEM of an LD -> mem_read drops immediately; no reg_write ever follows; state is IDLE.
REQ-026 Scenario (RETIRE_COUNT_EN): three ADDs plus one timed-out ST -> retired=3.
